// File: rtl/bit_4_sum_ser_pkg.sv
// Shared constants for the 4-bit ripple-carry adder.
package bit_4_sum_ser_pkg;

   localparam int unsigned ADD_W = 4;

endpackage

// File: rtl/sum_parr_cell.sv
// 1-bit combinational full adder, one stage of the ripple-carry chain.
module sum_parr_cell (
   output logic s,
   output logic c_o,
   input  logic a,
   input  logic c_i,
   input  logic b
);

   always_comb begin
      s   = a ^ b ^ c_i;
      c_o = (a & b) | (a & c_i) | (b & c_i);
   end

endmodule

// File: rtl/bit_4_sum_ser.sv
// 4-bit ripple-carry adder with registered sum, per-stage carries and valid.
module bit_4_sum_ser
   import bit_4_sum_ser_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [ADD_W-1:0] a,
   input  logic             c_i,
   input  logic [ADD_W-1:0] b,
   output logic [ADD_W-1:0] s,
   output logic [ADD_W-1:0] c_o,
   output logic             out_valid
);

   logic [ADD_W-1:0] sum;
   logic [ADD_W-1:0] carry;
   logic [ADD_W-1:0] cin;

   // Stage i takes the carry out of stage i-1; stage 0 takes the external carry-in.
   assign cin = {carry[ADD_W-2:0], c_i};

   for (genvar i = 0; i < ADD_W; i++) begin : g_stage
      sum_parr_cell u_cell (
         .s   (sum[i]),
         .c_o (carry[i]),
         .a   (a[i]),
         .c_i (cin[i]),
         .b   (b[i])
      );
   end

   // s and c_o hold their last result while in_valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s         <= '0;
         c_o       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s   <= sum;
            c_o <= carry;
         end
      end
   end

endmodule

// File: tb/tb_bit_4_sum_ser.sv
// Self-checking bench for bit_4_sum_ser against an arithmetic reference model.
module tb_bit_4_sum_ser;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] a;
   logic       c_i;
   logic [3:0] b;
   logic [3:0] s;
   logic [3:0] c_o;
   logic       out_valid;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_s;
   logic [3:0] exp_c;
   logic       exp_v;

   bit_4_sum_ser dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .c_i       (c_i),
      .b         (b),
      .s         (s),
      .c_o       (c_o),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Carry out of bit i is bit i+1 of the sum of the low i+1 bits of each operand.
   function automatic logic [3:0] ref_carry(input logic [3:0] x, input logic [3:0] y,
                                            input logic ci);
      logic [3:0] r;
      int unsigned m;
      int unsigned t;
      for (int i = 0; i < 4; i++) begin
         m = (32'd1 << (i + 1)) - 32'd1;
         t = (int'(x) & m) + (int'(y) & m) + int'(ci);
         r[i] = t[i+1];
      end
      return r;
   endfunction

   function automatic logic [3:0] ref_sum(input logic [3:0] x, input logic [3:0] y,
                                          input logic ci);
      logic [4:0] t;
      t = 5'(x) + 5'(y) + 5'(ci);
      return t[3:0];
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".s"}, s, exp_s);
      chk({tag, ".c_o"}, c_o, exp_c);
      chk({tag, ".out_valid"}, {3'b000, out_valid}, {3'b000, exp_v});
   endtask

   // Drive one operand set, advance one clock, update the model, sample 1 time unit later.
   task automatic step(input logic v, input logic [3:0] x, input logic [3:0] y,
                       input logic ci);
      in_valid = v;
      a        = x;
      b        = y;
      c_i      = ci;
      @(posedge clk);
      if (rst) begin
         exp_s = '0;
         exp_c = '0;
         exp_v = 1'b0;
      end else begin
         exp_v = v;
         if (v) begin
            exp_s = ref_sum(x, y, ci);
            exp_c = ref_carry(x, y, ci);
         end
      end
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      c_i      = 1'b0;
      exp_s    = '0;
      exp_c    = '0;
      exp_v    = 1'b0;
      #3;
      chk_all("reset");
      step(1'b1, 4'h5, 4'h3, 1'b1);
      chk_all("reset_hold");
      rst = 1'b0;

      // Directed cases with hand-computed expectations.
      step(1'b1, 4'h5, 4'h3, 1'b1);
      chk("5+3+1.s", s, 4'b1001);
      chk("5+3+1.c_o", c_o, 4'b0111);
      chk("5+3+1.v", {3'b000, out_valid}, 4'b0001);
      step(1'b1, 4'hF, 4'h1, 1'b0);
      chk("F+1.s", s, 4'b0000);
      chk("F+1.c_o", c_o, 4'b1111);
      step(1'b1, 4'hA, 4'h5, 1'b0);
      chk("A+5.s", s, 4'b1111);
      chk("A+5.c_o", c_o, 4'b0000);
      step(1'b1, 4'hF, 4'hF, 1'b1);
      chk("F+F+1.s", s, 4'b1111);
      chk("F+F+1.c_o", c_o, 4'b1111);
      step(1'b1, 4'h0, 4'h0, 1'b0);
      chk("0+0.s", s, 4'b0000);
      chk("0+0.c_o", c_o, 4'b0000);

      // Hold: result from a valid cycle must survive idle cycles with changing operands.
      step(1'b1, 4'h9, 4'h8, 1'b0);
      chk_all("pre_hold");
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
         chk("hold.s", s, 4'b0001);
         chk("hold.c_o", c_o, 4'b1000);
         chk("hold.v", {3'b000, out_valid}, 4'b0000);
      end

      // Asynchronous reset asserted mid-stream, between clock edges.
      step(1'b1, 4'h7, 4'h6, 1'b1);
      chk_all("pre_rst");
      #2 rst = 1'b1;
      exp_s = '0;
      exp_c = '0;
      exp_v = 1'b0;
      #1;
      chk_all("async_rst");
      step(1'b1, 4'hE, 4'h3, 1'b1);
      chk_all("rst_held");
      #2 rst = 1'b0;
      step(1'b0, 4'hE, 4'h3, 1'b1);
      chk_all("post_rst_idle");
      step(1'b1, 4'hE, 4'h3, 1'b1);
      chk_all("post_rst_first");

      // Exhaustive back-to-back sweep.
      for (int n = 0; n < 512; n++) begin
         step(1'b1, 4'(n), 4'(n >> 4), 1'(n >> 8));
         chk_all("sweep");
      end

      // Randomised stream with random valid gaps.
      for (int n = 0; n < 300; n++) begin
         step(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         chk_all("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
